port2axis_pack: RTL and testbench
=================================

PORT2AXIS_PACK -- requirements
Module: port2axis_pack

Interface
REQ-001 SHALL have parameter PORT_W, default 64, router port word width in bits (multiple of 8).
REQ-002 SHALL have parameter AXIS_W, default 128, AXI-Stream data width; AXIS_W/PORT_W = R, legal R in {1,2,4}.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, input buffer depth in port words (power of 2, >= 8).
REQ-004 SHALL have parameter BP_SLACK, default 4, words the upstream may still send after D_BP rises.
REQ-005 SHALL have parameters LEN_LSB (default 0) and LEN_W (default 16), locating the payload-length field in the header word.
REQ-006 SHALL have the port CLK, input, 1, the only clock; all logic on its rising edge.
REQ-007 SHALL have the port RST, input, 1, a synchronous, active-high reset.
REQ-008 SHALL have the port D, input, PORT_W, the router port word.
REQ-009 SHALL have the port D_VALID, input, 1, which qualifies D for one cycle.
REQ-010 SHALL have the port D_BP, output, 1, a registered backpressure request to the upstream.
REQ-011 SHALL have the outputs M_AXIS_TDATA (AXIS_W), M_AXIS_TKEEP (AXIS_W/8), M_AXIS_TLAST (1) and M_AXIS_TVALID (1), forming the AXI-Stream master.
REQ-012 SHALL have the port M_AXIS_TREADY, input, 1, the AXI-Stream sink ready.
REQ-013 SHALL have the port PKT_CNT, output, 32, the count of packets completed on AXIS.
REQ-014 SHALL have the port OVF, output, 1, a sticky flag set when a word is dropped because the buffer was full.

Function
REQ-015 SHALL accept a word on every cycle with D_VALID=1 (no ready); word written to FIFO with computed last flag.
REQ-016 SHALL frame at input: states HDR, BODY; in HDR, accepted word is header, LEN = D[LEN_LSB+:LEN_W].
REQ-017 SHALL, in HDR with LEN=0, mark header last and stay HDR; LEN>0 load remaining counter = LEN, go BODY.
REQ-018 SHALL, in BODY, decrement remaining per accepted word; word taken when remaining=1 is last, next state HDR.
REQ-019 SHALL register D_BP = 1 when FIFO occupancy >= FIFO_DEPTH - BP_SLACK, else 0.
REQ-020 SHALL, on D_VALID while FIFO full, drop the word, leave framing state unchanged and set OVF (held until RST).
REQ-021 SHALL pack popped words little-endian: slot k occupies TDATA[k*PORT_W +: PORT_W], k = 0..R-1.
REQ-022 SHALL close a beat when slot R-1 is filled or the word is last; packets never share a beat.
REQ-023 SHALL set TKEEP to PORT_W/8 ones per filled slot, zero elsewhere; unfilled slots' TDATA = 0.
REQ-024 SHALL assert TLAST only on the beat holding a packet's last word.
REQ-025 SHALL hold TDATA/TKEEP/TLAST/TVALID stable while TVALID=1 and TREADY=0.
REQ-026 SHALL pop at most one word per cycle, and SHALL sustain one beat per cycle when R=1 and TREADY=1.
REQ-027 SHALL present TVALID no earlier than 2 cycles and no later than 3 cycles after the closing word is accepted on D, given an empty pipeline and TREADY=1.
REQ-028 SHALL increment PKT_CNT on each TVALID&TREADY&TLAST cycle, wrapping at 2^32-1 to 0.
REQ-029 SHALL treat simultaneous FIFO push and pop as occupancy unchanged; full with pop permits push.

Reset
REQ-030 SHALL, while RST=1, drive TVALID=0, TLAST=0, TKEEP=0, TDATA=0, PKT_CNT=0, OVF=0 and D_BP=1.
REQ-031 SHALL empty the FIFO, clear the packer and framer to HDR; D_BP falls the first cycle after RST deasserts.
REQ-032 SHALL, on reset mid-packet, discard partial data; the first word after reset is a header.

Verification
REQ-033 SHALL be verified with R=2, header LEN=2 then A, B: beat1 {A,H} TKEEP=FFFF TLAST=0; beat2 {0,B} TKEEP=00FF TLAST=1; PKT_CNT=1.
REQ-034 SHALL be verified with a header-only packet (LEN=0): exactly one beat, TKEEP=00FF, TLAST=1.
REQ-035 SHALL be verified with TREADY=0 and a 20-word stream whose sender stops within 4 cycles of D_BP: D_BP rises at occupancy 12, OVF stays 0; on release all words emerge in order.
REQ-036 SHALL be verified with TREADY=0 and a sender ignoring D_BP: the 17th buffered word is dropped, OVF=1 and stays 1 until RST.
REQ-037 SHALL be verified with RST pulsed after header(LEN=5)+1 word, then packet LEN=1 (H2, X): single beat {X,H2}, TLAST=1, no residue.
REQ-038 SHALL be verified with TREADY held 0 for 3 cycles during TVALID: outputs stable, beat taken once, no duplication.

Source files
------------

// File: rtl/port2axis_pack.sv
// Router port to AXI-Stream packer: frames incoming words by header length,
// buffers them in a FIFO and packs R words per beat, never mixing packets.
module port2axis_pack #(
    parameter int PORT_W     = 64,
    parameter int AXIS_W     = 128,
    parameter int FIFO_DEPTH = 16,
    parameter int BP_SLACK   = 4,
    parameter int LEN_LSB    = 0,
    parameter int LEN_W      = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [PORT_W-1:0]   D,
    input  logic                D_VALID,
    output logic                D_BP,
    output logic [AXIS_W-1:0]   M_AXIS_TDATA,
    output logic [AXIS_W/8-1:0] M_AXIS_TKEEP,
    output logic                M_AXIS_TLAST,
    output logic                M_AXIS_TVALID,
    input  logic                M_AXIS_TREADY,
    output logic [31:0]         PKT_CNT,
    output logic                OVF
);

    localparam int R   = AXIS_W / PORT_W;
    localparam int KW  = AXIS_W / 8;
    localparam int PKW = PORT_W / 8;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int SW  = (R > 1) ? $clog2(R) : 1;

    typedef enum logic {HDR, BODY} frame_t;

    frame_t              frame_q, frame_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [PORT_W:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                bp_q, bp_d;
    logic                ovf_q, ovf_d;
    logic [31:0]         pkt_cnt_q, pkt_cnt_d;
    logic [AXIS_W-1:0]   acc_data_q, acc_data_d;
    logic [KW-1:0]       acc_keep_q, acc_keep_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [AXIS_W-1:0]   tdata_q, tdata_d;
    logic [KW-1:0]       tkeep_q, tkeep_d;
    logic                tlast_q, tlast_d;
    logic                tvalid_q, tvalid_d;

    logic                full, empty, push, pop, drop, closes, out_free, last_in;
    logic [LEN_W-1:0]    len_in;
    logic [PORT_W-1:0]   head_data;
    logic                head_last;
    logic [AXIS_W-1:0]   beat_data;
    logic [KW-1:0]       beat_keep;

    assign full      = (cnt_q == CW'(FIFO_DEPTH));
    assign empty     = (cnt_q == '0);
    assign head_data = mem_q[rd_ptr_q][PORT_W-1:0];
    assign head_last = mem_q[rd_ptr_q][PORT_W];
    assign out_free  = !tvalid_q || M_AXIS_TREADY;
    assign closes    = head_last || (slot_q == SW'(R - 1));
    // A word that would close a beat may only leave the FIFO when the output register can take it.
    assign pop       = !empty && (!closes || out_free);
    assign push      = D_VALID && (!full || pop);
    assign drop      = D_VALID && full && !pop;
    assign len_in    = D[LEN_LSB +: LEN_W];

    always_comb begin
        frame_d = frame_q;
        rem_d   = rem_q;
        last_in = 1'b0;
        if (push) begin
            if (frame_q == HDR) begin
                if (len_in == '0) begin
                    last_in = 1'b1;
                end else begin
                    rem_d   = len_in;
                    frame_d = BODY;
                end
            end else begin
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    last_in = 1'b1;
                    frame_d = HDR;
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
        bp_d      = (cnt_d >= CW'(FIFO_DEPTH - BP_SLACK));
        ovf_d     = ovf_q || drop;
        pkt_cnt_d = pkt_cnt_q;
        if (tvalid_q && M_AXIS_TREADY && tlast_q) pkt_cnt_d = pkt_cnt_q + 32'd1;
    end

    always_comb begin
        beat_data = acc_data_q;
        beat_keep = acc_keep_q;
        for (int k = 0; k < R; k++) begin
            if (slot_q == SW'(k)) begin
                beat_data[k*PORT_W +: PORT_W] = head_data;
                beat_keep[k*PKW +: PKW]       = '1;
            end
        end
        acc_data_d = acc_data_q;
        acc_keep_d = acc_keep_q;
        slot_d     = slot_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tlast_d    = tlast_q;
        tvalid_d   = tvalid_q;
        if (tvalid_q && M_AXIS_TREADY) tvalid_d = 1'b0;
        if (pop) begin
            if (closes) begin
                tdata_d    = beat_data;
                tkeep_d    = beat_keep;
                tlast_d    = head_last;
                tvalid_d   = 1'b1;
                acc_data_d = '0;
                acc_keep_d = '0;
                slot_d     = '0;
            end else begin
                acc_data_d = beat_data;
                acc_keep_d = beat_keep;
                slot_d     = slot_q + SW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= {last_in, D};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_q    <= HDR;
            rem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            bp_q       <= 1'b1;
            ovf_q      <= 1'b0;
            pkt_cnt_q  <= '0;
            acc_data_q <= '0;
            acc_keep_q <= '0;
            slot_q     <= '0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
        end else begin
            frame_q    <= frame_d;
            rem_q      <= rem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            bp_q       <= bp_d;
            ovf_q      <= ovf_d;
            pkt_cnt_q  <= pkt_cnt_d;
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
            slot_q     <= slot_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
        end
    end

    assign D_BP          = bp_q;
    assign OVF           = ovf_q;
    assign PKT_CNT       = pkt_cnt_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TKEEP  = tkeep_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign M_AXIS_TVALID = tvalid_q;

endmodule

// File: tb/tb_port2axis_pack.sv
// Bench for port2axis_pack with R=2: directed packet table, corner sequences
// and randomized traffic checked against a packet-level beat model.
`timescale 1ns/1ps
module tb_port2axis_pack;

    localparam int BP_SLACK = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic [63:0]   D;
    logic          D_VALID;
    logic          D_BP;
    logic [127:0]  TDATA;
    logic [15:0]   TKEEP;
    logic          TLAST, TVALID, TREADY;
    logic [31:0]   PKT_CNT;
    logic          OVF;

    port2axis_pack #(.PORT_W(64), .AXIS_W(128), .FIFO_DEPTH(16), .BP_SLACK(BP_SLACK),
                     .LEN_LSB(0), .LEN_W(16)) dut (
        .CLK(CLK), .RST(RST), .D(D), .D_VALID(D_VALID), .D_BP(D_BP),
        .M_AXIS_TDATA(TDATA), .M_AXIS_TKEEP(TKEEP), .M_AXIS_TLAST(TLAST),
        .M_AXIS_TVALID(TVALID), .M_AXIS_TREADY(TREADY), .PKT_CNT(PKT_CNT), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } beat_t;

    typedef struct {
        int          len;
        int          beats;
        logic [15:0] last_keep;
    } vec_t;

    beat_t       exp_q[$];
    logic [63:0] pkt_w[$];
    int          checks = 0;
    int          errors = 0;
    int          beats_seen = 0;
    logic [15:0] last_keep_seen = '0;
    bit          rand_rdy = 0;
    bit          prev_stall = 0;
    beat_t       prev_beat;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock: observe outputs at the falling edge, then return 1ns after the rising edge.
    task automatic tick();
        beat_t b;
        @(negedge CLK);
        if (RST) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_tdata", TDATA, prev_beat.data);
                chk("hold_tkeep", 128'(TKEEP), 128'(prev_beat.keep));
                chk("hold_tlast", 128'(TLAST), 128'(prev_beat.last));
                chk("hold_tvalid", 128'(TVALID), 128'(1));
            end
            if (TVALID && TREADY) begin
                beats_seen++;
                last_keep_seen = TKEEP;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: actual tdata=%0h required no beat", TDATA);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_tdata", TDATA, b.data);
                    chk("beat_tkeep", 128'(TKEEP), 128'(b.keep));
                    chk("beat_tlast", 128'(TLAST), 128'(b.last));
                end
            end
            prev_stall     = TVALID && !TREADY;
            prev_beat.data = TDATA;
            prev_beat.keep = TKEEP;
            prev_beat.last = TLAST;
        end
        @(posedge CLK);
        #1;
        if (rand_rdy) TREADY = ($urandom_range(0, 9) < 7);
    endtask

    // Builds a packet (header + len words) and, if asked, the beats it must produce.
    task automatic build_pkt(input int len, input bit expect_out);
        logic [63:0] w;
        beat_t       b;
        pkt_w.delete();
        w = {$urandom, $urandom};
        w[15:0] = len[15:0];
        pkt_w.push_back(w);
        for (int i = 0; i < len; i++) pkt_w.push_back({$urandom, $urandom});
        if (expect_out) begin
            for (int i = 0; i < pkt_w.size(); i += 2) begin
                b.data = {64'h0, pkt_w[i]};
                b.keep = 16'h00FF;
                if (i + 1 < pkt_w.size()) begin
                    b.data[127:64] = pkt_w[i+1];
                    b.keep = 16'hFFFF;
                end
                b.last = (i + 2 >= pkt_w.size());
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic send_pkt(input int max_gap);
        int n;
        for (int i = 0; i < pkt_w.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) tick();
            n = 0;
            while (D_BP && n < 2000) begin
                tick();
                n++;
            end
            if (n >= 2000) begin
                checks++;
                errors++;
                $display("FAIL bp_wait_timeout: actual D_BP=1 required 0 within 2000 cycles");
                return;
            end
            D = pkt_w[i];
            D_VALID = 1'b1;
            tick();
            D_VALID = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || TVALID) && n < 3000) begin
            tick();
            n++;
        end
        chk("drain_remaining", 128'(exp_q.size()), 128'(0));
    endtask

    vec_t tbl[6];

    initial begin
        int base_beats, idx, after, seen, n, lat;
        bit released;
        logic [31:0] base_cnt;

        tbl[0] = '{2, 2, 16'h00FF};
        tbl[1] = '{0, 1, 16'h00FF};
        tbl[2] = '{1, 1, 16'hFFFF};
        tbl[3] = '{3, 2, 16'hFFFF};
        tbl[4] = '{4, 3, 16'h00FF};
        tbl[5] = '{5, 3, 16'hFFFF};

        TREADY = 1'b1; D = '0; D_VALID = 1'b0; RST = 1'b1;
        tick(); tick();
        chk("rst_tvalid", 128'(TVALID), 128'(0));
        chk("rst_tlast", 128'(TLAST), 128'(0));
        chk("rst_tkeep", 128'(TKEEP), 128'(0));
        chk("rst_tdata", TDATA, 128'(0));
        chk("rst_pkt_cnt", 128'(PKT_CNT), 128'(0));
        chk("rst_ovf", 128'(OVF), 128'(0));
        chk("rst_d_bp", 128'(D_BP), 128'(1));
        RST = 1'b0;
        tick();
        chk("d_bp_after_rst", 128'(D_BP), 128'(0));

        // Directed packet table
        for (int t = 0; t < 6; t++) begin
            base_beats = beats_seen;
            base_cnt   = PKT_CNT;
            build_pkt(tbl[t].len, 1);
            send_pkt(0);
            drain();
            chk("tbl_beats", 128'(beats_seen - base_beats), 128'(tbl[t].beats));
            chk("tbl_last_keep", 128'(last_keep_seen), 128'(tbl[t].last_keep));
            chk("tbl_pkt_cnt", 128'(PKT_CNT), 128'(base_cnt + 32'd1));
        end

        // Latency from the closing word on D to TVALID
        build_pkt(0, 1);
        D = pkt_w[0];
        D_VALID = 1'b1;
        tick();
        D_VALID = 1'b0;
        lat = 1;
        while (!TVALID && lat < 6) begin
            tick();
            lat++;
        end
        checks++;
        if (lat < 2 || lat > 3) begin
            errors++;
            $display("FAIL latency: actual=%0d cycles required 2..3", lat);
        end
        drain();

        // Output held for 3 stalled cycles, taken exactly once
        TREADY = 1'b0;
        base_beats = beats_seen;
        base_cnt   = PKT_CNT;
        build_pkt(1, 1);
        send_pkt(0);
        n = 0;
        while (!TVALID && n < 10) begin
            tick();
            n++;
        end
        chk("stall_tvalid", 128'(TVALID), 128'(1));
        repeat (3) tick();
        TREADY = 1'b1;
        drain();
        repeat (3) tick();
        chk("stall_beats", 128'(beats_seen - base_beats), 128'(1));
        chk("stall_pkt_cnt", 128'(PKT_CNT), 128'(base_cnt + 32'd1));

        // 20-word stream against a stalled sink; sender uses the full slack after D_BP
        TREADY = 1'b0;
        base_cnt = PKT_CNT;
        build_pkt(19, 1);
        idx = 0; after = 0; seen = -1; n = 0; released = 0;
        while (idx < 20 && n < 500) begin
            if (D_BP && seen < 0) seen = idx;
            if (!D_BP) after = 0;
            if (D_BP && after >= BP_SLACK && !released) begin
                chk("bp_ovf_held", 128'(OVF), 128'(0));
                checks++;
                if (seen < 12 || seen > 15) begin
                    errors++;
                    $display("FAIL bp_rise_point: actual=%0d words required 12..15", seen);
                end
                TREADY = 1'b1;
                released = 1;
            end
            if (!D_BP || after < BP_SLACK) begin
                if (D_BP) after++;
                D = pkt_w[idx];
                D_VALID = 1'b1;
                idx++;
            end else begin
                D_VALID = 1'b0;
            end
            tick();
            n++;
        end
        D_VALID = 1'b0;
        chk("bp_released", 128'(released), 128'(1));
        TREADY = 1'b1;
        drain();
        chk("bp_ovf_final", 128'(OVF), 128'(0));
        chk("bp_pkt_cnt", 128'(PKT_CNT), 128'(base_cnt + 32'd1));

        // Sender ignoring D_BP overruns the buffer
        TREADY = 1'b0;
        build_pkt(40, 0);
        for (int i = 0; i < 30; i++) begin
            D = pkt_w[i];
            D_VALID = 1'b1;
            tick();
            if (i == 15) chk("ovf_before_full", 128'(OVF), 128'(0));
        end
        D_VALID = 1'b0;
        chk("ovf_set", 128'(OVF), 128'(1));
        repeat (5) tick();
        chk("ovf_sticky", 128'(OVF), 128'(1));
        RST = 1'b1;
        tick();
        exp_q.delete();
        chk("ovf_cleared", 128'(OVF), 128'(0));
        chk("ovf_rst_tvalid", 128'(TVALID), 128'(0));
        chk("ovf_rst_pkt_cnt", 128'(PKT_CNT), 128'(0));
        RST = 1'b0;
        tick();

        // Reset in the middle of a packet, then a fresh packet
        TREADY = 1'b0;
        build_pkt(5, 0);
        for (int i = 0; i < 2; i++) begin
            D = pkt_w[i];
            D_VALID = 1'b1;
            tick();
        end
        D_VALID = 1'b0;
        repeat (3) tick();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        tick();
        TREADY = 1'b1;
        base_beats = beats_seen;
        build_pkt(1, 1);
        send_pkt(0);
        drain();
        repeat (3) tick();
        chk("mid_rst_beats", 128'(beats_seen - base_beats), 128'(1));
        chk("mid_rst_pkt_cnt", 128'(PKT_CNT), 128'(1));

        // Randomized traffic with random sink readiness
        base_cnt = PKT_CNT;
        rand_rdy = 1;
        for (int p = 0; p < 40; p++) begin
            build_pkt($urandom_range(0, 9), 1);
            send_pkt(3);
        end
        rand_rdy = 0;
        TREADY = 1'b1;
        drain();
        chk("rand_pkt_cnt", 128'(PKT_CNT), 128'(base_cnt + 32'd40));
        chk("rand_ovf", 128'(OVF), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
